// File: rtl/cotm32_pkg.sv
// Shared core-wide widths and the fetch response record.
package cotm32_pkg;

    localparam int XLEN       = 32;
    localparam int INST_WIDTH = 32;

    typedef struct packed {
        logic [XLEN-1:0]       addr;
        logic [INST_WIDTH-1:0] inst;
        logic                  fault;
    } fetch_rsp_t;

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Synchronous power-of-two FIFO holding fetch responses until the consumer takes them.
module fetch_rsp_fifo
    import cotm32_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_rsp_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    input  logic                   clear,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two; clear wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_resp.sv
// Fetch responder: issues instruction memory reads and returns ordered {inst, addr, fault} responses.
module inst_fetch_resp
    import cotm32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [XLEN-1:0]       i_req_addr,
    input  logic                  i_flush,
    output logic                  o_mem_en,
    output logic [XLEN-1:0]       o_mem_addr,
    input  logic [INST_WIDTH-1:0] i_mem_rdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [INST_WIDTH-1:0] o_rsp_inst,
    output logic [XLEN-1:0]       o_rsp_addr,
    output logic                  o_rsp_fault
);

    localparam int AW = $clog2(DEPTH);

    logic            inflight_valid;
    logic            inflight_fault;
    logic [XLEN-1:0] inflight_addr;
    logic [AW:0]     count;
    logic [AW:0]     occ;
    logic            full;
    logic            empty;
    logic            accept;
    logic            misaligned;
    logic            push;
    logic            pop;
    fetch_rsp_t      push_data;
    fetch_rsp_t      head;

    // Credit counts the in-flight read so a push one cycle later always finds room.
    assign occ         = count + (AW+1)'(inflight_valid);
    assign o_req_ready = !i_rst && !i_flush && !full && (occ < (AW+1)'(DEPTH));
    assign accept      = i_req_valid && o_req_ready;
    assign misaligned  = (i_req_addr[1:0] != 2'b00);
    assign o_mem_en    = accept && !misaligned;
    assign o_mem_addr  = o_mem_en ? i_req_addr : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight_valid <= 1'b0;
            inflight_addr  <= '0;
            inflight_fault <= 1'b0;
        end else begin
            inflight_valid <= accept;
            inflight_addr  <= i_req_addr;
            inflight_fault <= misaligned;
        end
    end

    // Data returning during a flush cycle belongs to a discarded fetch.
    assign push           = inflight_valid && !i_flush;
    assign push_data.addr  = inflight_addr;
    assign push_data.inst  = inflight_fault ? '0 : i_mem_rdata;
    assign push_data.fault = inflight_fault;

    fetch_rsp_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_rsp_t)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (i_flush),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign o_rsp_valid = !i_rst && !i_flush && !empty;
    assign pop         = o_rsp_valid && i_rsp_ready;
    assign o_rsp_inst  = o_rsp_valid ? head.inst  : '0;
    assign o_rsp_addr  = o_rsp_valid ? head.addr  : '0;
    assign o_rsp_fault = o_rsp_valid ? head.fault : 1'b0;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Self-checking bench for inst_fetch_resp: directed tables, corner sequences and random traffic.
module tb_inst_fetch_resp;

    logic        i_clk;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_flush;
    logic        o_mem_en;
    logic [31:0] o_mem_addr;
    logic [31:0] i_mem_rdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_inst;
    logic [31:0] o_rsp_addr;
    logic        o_rsp_fault;

    inst_fetch_resp #(.DEPTH(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_addr  (i_req_addr),
        .i_flush     (i_flush),
        .o_mem_en    (o_mem_en),
        .o_mem_addr  (o_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_inst  (o_rsp_inst),
        .o_rsp_addr  (o_rsp_addr),
        .o_rsp_fault (o_rsp_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0000_0013;
    endfunction

    // Memory model: answers enabled reads one cycle later, garbage otherwise.
    always @(posedge i_clk) begin
        i_mem_rdata <= o_mem_en ? mem_word(o_mem_addr) : $urandom();
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        fault;
        int          due;
    } exp_t;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic        rsp_ready;
        logic        flush;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_addr;
    } vec_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   seen = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply_stimulus(logic v, logic [31:0] a, logic rr, logic f);
        @(negedge i_clk);
        i_req_valid = v;
        i_req_addr  = a;
        i_rsp_ready = rr;
        i_flush     = f;
        #1;
    endtask

    // Reference: every accepted request is an outstanding slot until popped; it becomes visible two cycles after acceptance.
    task automatic check_output();
        logic exp_ready;
        logic exp_valid;
        logic exp_en;
        logic mis;
        if (i_rst) q.delete();
        exp_ready = !i_rst && !i_flush && (q.size() < 4);
        exp_valid = !i_rst && !i_flush && (q.size() > 0) && (q[0].due <= cyc);
        exp_en    = i_req_valid && exp_ready && (i_req_addr[1:0] == 2'b00);
        mis       = (i_req_addr[1:0] != 2'b00);
        check("req_ready", 32'(o_req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(o_rsp_valid), 32'(exp_valid));
        check("mem_en", 32'(o_mem_en), 32'(exp_en));
        if (exp_en || i_rst) check("mem_addr", o_mem_addr, exp_en ? i_req_addr : 32'h0);
        if (exp_valid) begin
            check("rsp_addr", o_rsp_addr, q[0].addr);
            check("rsp_inst", o_rsp_inst, q[0].inst);
            check("rsp_fault", 32'(o_rsp_fault), 32'(q[0].fault));
        end else if (i_rst) begin
            check("rst_addr", o_rsp_addr, 32'h0);
            check("rst_inst", o_rsp_inst, 32'h0);
            check("rst_fault", 32'(o_rsp_fault), 32'h0);
        end
        if (exp_valid && i_rsp_ready) begin
            void'(q.pop_front());
            seen++;
        end
        if (i_flush) q.delete();
        if (i_req_valid && exp_ready)
            q.push_back('{addr: i_req_addr, inst: mis ? 32'h0 : mem_word(i_req_addr),
                          fault: mis, due: cyc + 2});
    endtask

    task automatic tick();
        @(posedge i_clk);
        cyc++;
    endtask

    task automatic cycle(logic v, logic [31:0] a, logic rr, logic f);
        apply_stimulus(v, a, rr, f);
        check_output();
        tick();
    endtask

    task automatic do_reset(int n);
        i_rst = 1'b1;
        repeat (n) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        #1 i_rst = 1'b0;
    endtask

    vec_t tbl[11];

    initial begin
        logic [31:0] a;
        i_rst = 1'b1;
        i_req_valid = 1'b0;
        i_req_addr = '0;
        i_rsp_ready = 1'b0;
        i_flush = 1'b0;

        tbl[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00};
        tbl[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00};
        tbl[5]  = '{1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00};
        tbl[6]  = '{1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h04};
        tbl[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08};
        tbl[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0C};
        tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10};
        tbl[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00};

        // Reset hold, then first fetch latency.
        do_reset(3);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        check("t1_valid", 32'(o_rsp_valid), 32'h1);
        check("t1_inst", o_rsp_inst, 32'h13);
        check("t1_addr", o_rsp_addr, 32'h0);
        check_output();
        tick();

        // Back-to-back fetches with free-flowing responses.
        seen = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i * 4), 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("t2_count", 32'(seen), 32'd8);

        // Backpressure table from an empty pipeline.
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(tbl[i].valid, tbl[i].addr, tbl[i].rsp_ready, tbl[i].flush);
            check("tbl_ready", 32'(o_req_ready), 32'(tbl[i].exp_ready));
            check("tbl_valid", 32'(o_rsp_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) check("tbl_addr", o_rsp_addr, tbl[i].exp_addr);
            check_output();
            tick();
        end

        // Misaligned fetch between aligned neighbours.
        apply_stimulus(1'b1, 32'h102, 1'b1, 1'b0);
        check("t4_mem_en", 32'(o_mem_en), 32'h0);
        check_output();
        tick();
        cycle(1'b1, 32'h104, 1'b1, 1'b0);
        cycle(1'b1, 32'h0FC, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with two buffered and one in flight.
        cycle(1'b1, 32'h00, 1'b0, 1'b0);
        cycle(1'b1, 32'h04, 1'b0, 1'b0);
        cycle(1'b1, 32'h08, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0C, 1'b1, 1'b1);
        check("t5_flush_valid", 32'(o_rsp_valid), 32'h0);
        check("t5_flush_ready", 32'(o_req_ready), 32'h0);
        check_output();
        tick();
        seen = 0;
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h100, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_count", 32'(seen), 32'd1);

        // Asynchronous reset with three entries buffered.
        repeat (3) cycle(1'b1, 32'h200, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        i_rst = 1'b1;
        #1;
        check("t6_valid", 32'(o_rsp_valid), 32'h0);
        check_output();
        tick();
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        #1 i_rst = 1'b0;
        seen = 0;
        repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("t6_stale", 32'(seen), 32'h0);

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            cycle($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 3);
        end
        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
